// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz sequencer: state encoding, ROM record
// field positions, and the LFSR / key-legality helpers.
package quiz_pkg;

  localparam int IDX_W    = 4;
  localparam int REC_W    = 24;
  localparam int PROB_MSB = 23;
  localparam int PROB_LSB = 12;
  localparam int ANS_MSB  = 11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, PICK, FETCH, LOAD, ANSWER, JUDGE, RESULT, DONE
  } state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic key_legal(input logic [IDX_W-1:0] k);
    return (k >= 4'd1) && (k <= 4'd9);
  endfunction

endpackage

// File: rtl/quiz_sort3.sv
// Three-entry compare/swap sort into answer order: largest index in slot 0,
// zeros fall to the top slot, so the packed word reads ascending as hex.
module quiz_sort3
  import quiz_pkg::*;
(
  input  logic [3*IDX_W-1:0] ent_i,
  output logic [3*IDX_W-1:0] sorted_o
);

  logic [IDX_W-1:0] a0, a1, a2, b0, b1, c1, c2, d0, d1;

  always_comb begin
    a0 = ent_i[IDX_W-1:0];
    a1 = ent_i[2*IDX_W-1:IDX_W];
    a2 = ent_i[3*IDX_W-1:2*IDX_W];
    if (a1 > a0) begin b0 = a1; b1 = a0; end
    else         begin b0 = a0; b1 = a1; end
    if (a2 > b1) begin c1 = a2; c2 = b1; end
    else         begin c1 = b1; c2 = a2; end
    if (c1 > b0) begin d0 = c1; d1 = b0; end
    else         begin d0 = b0; d1 = c1; end
    sorted_o = {c2, d1, d0};
  end

endmodule

// File: rtl/quiz_seq_ctrl.sv
// Prime-factorization quiz sequencer: picks a question, loads the ROM record,
// collects key entries under a time limit, judges and keeps round/score.
// Define QUIZ_SEQ_NO_REPEAT_EN to forbid picking the previous question again.
module quiz_seq_ctrl
  import quiz_pkg::*;
#(
  parameter int Q_COUNT    = 8,
  parameter int NUM_ROUNDS = 5,
  parameter int TIME_LIMIT = 30,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 KEY_VALID,
  input  logic [IDX_W-1:0]     KEY_IDX,
  input  logic                 KEY_CLR,
  input  logic                 KEY_ENT,
  input  logic [REC_W-1:0]     QUESTION,
  output logic [IDX_W-1:0]     NUM_OUT,
  output logic [11:0]          PROBLEM_BCD,
  output logic [3*IDX_W-1:0]   ENTRY,
  output logic [1:0]           ENTRY_CNT,
  output logic [7:0]           TIME_LEFT,
  output logic [3:0]           SCORE,
  output logic [3:0]           ROUND,
  output logic                 BUSY,
  output logic                 RESULT_VALID,
  output logic                 RESULT_OK,
  output logic                 GAME_DONE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] QMAX      = IDX_W'(Q_COUNT);
  localparam logic [7:0]       TL_INIT   = 8'(TIME_LIMIT);
  localparam logic [3:0]       RMAX      = 4'(NUM_ROUNDS);

  state_e                state_q, state_d;
  logic [7:0]            lfsr_q;
  logic [IDX_W-1:0]      num_q, num_d;
  logic [11:0]           prob_q, prob_d;
  logic [ANS_MSB:0]      ans_q, ans_d;
  logic [3*IDX_W-1:0]    ent_q, ent_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            tl_q, tl_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [3:0]            score_q, score_d;
  logic [3:0]            round_q, round_d;
  logic                  ok_q, ok_d;
  logic                  tmo_q, tmo_d;

  logic [IDX_W-1:0]      cand;
  logic                  cand_ok;
  logic                  wrap;
  logic                  key_ok;
  logic [3*IDX_W-1:0]    sorted;

  assign cand   = lfsr_q[IDX_W-1:0];
  assign wrap   = (presc_q == PRESC_MAX);
  assign key_ok = KEY_VALID && key_legal(KEY_IDX) && (cnt_q != 2'd3);

`ifdef QUIZ_SEQ_NO_REPEAT_EN
  logic [IDX_W-1:0] prev_q, prev_d;
  assign cand_ok = (cand != '0) && (cand <= QMAX) && (cand != prev_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  always_comb begin
    prev_d = prev_q;
    if ((state_q == IDLE || state_q == DONE) && START) prev_d = '0;
    else if (state_q == PICK && cand_ok)               prev_d = cand;
  end
`else
  assign cand_ok = (cand != '0) && (cand <= QMAX);
`endif

  quiz_sort3 u_sort (
    .ent_i    (ent_q),
    .sorted_o (sorted)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      num_q   <= '0;
      prob_q  <= '0;
      ans_q   <= '0;
      ent_q   <= '0;
      cnt_q   <= '0;
      tl_q    <= '0;
      presc_q <= '0;
      score_q <= '0;
      round_q <= '0;
      ok_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_step(lfsr_q);
      num_q   <= num_d;
      prob_q  <= prob_d;
      ans_q   <= ans_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
      tl_q    <= tl_d;
      presc_q <= presc_d;
      score_q <= score_d;
      round_q <= round_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    prob_d  = prob_q;
    ans_d   = ans_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    tl_d    = tl_q;
    presc_d = presc_q;
    score_d = score_q;
    round_d = round_q;
    ok_d    = ok_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE, DONE: begin
        if (START) begin
          score_d = '0;
          round_d = 4'd1;
          state_d = PICK;
        end
      end
      PICK: begin
        if (cand_ok) begin
          num_d   = cand;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        prob_d  = QUESTION[PROB_MSB:PROB_LSB];
        ans_d   = QUESTION[ANS_MSB:0];
        ent_d   = '0;
        cnt_d   = '0;
        tl_d    = TL_INIT;
        presc_d = '0;
        tmo_d   = 1'b0;
        state_d = ANSWER;
      end
      ANSWER: begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        if (wrap) tl_d = tl_q - 8'd1;
        // the last tick expiring beats every key action in the same cycle
        if (wrap && tl_q == 8'd1) begin
          tmo_d   = 1'b1;
          state_d = JUDGE;
        end else if (KEY_ENT) begin
          state_d = JUDGE;
        end else if (KEY_CLR) begin
          ent_d = '0;
          cnt_d = '0;
        end else if (key_ok) begin
          case (cnt_q)
            2'd0:    ent_d[IDX_W-1:0]         = KEY_IDX;
            2'd1:    ent_d[2*IDX_W-1:IDX_W]   = KEY_IDX;
            default: ent_d[3*IDX_W-1:2*IDX_W] = KEY_IDX;
          endcase
          cnt_d = cnt_q + 2'd1;
        end
      end
      JUDGE: begin
        ok_d = (sorted == ans_q) && !tmo_q;
        if (ok_d && score_q != 4'hF) score_d = score_q + 4'd1;
        presc_d = '0;
        state_d = RESULT;
      end
      RESULT: begin
        presc_d = presc_q + 1'b1;
        if (wrap) begin
          presc_d = '0;
          if (round_q == RMAX) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = PICK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign NUM_OUT      = num_q;
  assign PROBLEM_BCD  = prob_q;
  assign ENTRY        = ent_q;
  assign ENTRY_CNT    = cnt_q;
  assign TIME_LEFT    = tl_q;
  assign SCORE        = score_q;
  assign ROUND        = round_q;
  assign BUSY         = (state_q != IDLE) && (state_q != DONE);
  assign RESULT_VALID = (state_q == RESULT);
  assign RESULT_OK    = ok_q;
  assign GAME_DONE    = (state_q == DONE);

endmodule

// File: tb/tb_quiz_seq_ctrl.sv
// Directed bench for quiz_seq_ctrl with a registered bench ROM and a
// transaction-level scoreboard of entries, score, round and verdicts.
module tb_quiz_seq_ctrl;

  localparam int QC = 8;
  localparam int NR = 2;
  localparam int TL = 2;
  localparam int TD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0, KEY_VALID = 1'b0, KEY_CLR = 1'b0, KEY_ENT = 1'b0;
  logic [3:0]  KEY_IDX = 4'd0;
  logic [23:0] QUESTION = 24'd0;
  logic [3:0]  NUM_OUT;
  logic [11:0] PROBLEM_BCD;
  logic [11:0] ENTRY;
  logic [1:0]  ENTRY_CNT;
  logic [7:0]  TIME_LEFT;
  logic [3:0]  SCORE, ROUND;
  logic        BUSY, RESULT_VALID, RESULT_OK, GAME_DONE;

  quiz_seq_ctrl #(.Q_COUNT(QC), .NUM_ROUNDS(NR), .TIME_LIMIT(TL), .TICK_DIV(TD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .KEY_VALID(KEY_VALID), .KEY_IDX(KEY_IDX),
    .KEY_CLR(KEY_CLR), .KEY_ENT(KEY_ENT), .QUESTION(QUESTION), .NUM_OUT(NUM_OUT),
    .PROBLEM_BCD(PROBLEM_BCD), .ENTRY(ENTRY), .ENTRY_CNT(ENTRY_CNT),
    .TIME_LEFT(TIME_LEFT), .SCORE(SCORE), .ROUND(ROUND), .BUSY(BUSY),
    .RESULT_VALID(RESULT_VALID), .RESULT_OK(RESULT_OK), .GAME_DONE(GAME_DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] rom_f(input logic [3:0] i);
    case (i)
      4'd1:    return 24'h027222;
      4'd2:    return 24'h042124;
      4'd3:    return 24'h015023;
      4'd4:    return 24'h006012;
      4'd5:    return 24'h007004;
      4'd6:    return 24'h030123;
      4'd7:    return 24'h011005;
      4'd8:    return 24'h022015;
      default: return 24'h000000;
    endcase
  endfunction

  always @(posedge CLK) QUESTION <= rom_f(NUM_OUT);

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] lm;
  always @(posedge CLK or posedge RST)
    if (RST) lm <= 8'hA5;
    else     lm <= lfsr_next(lm);

  int checks = 0;
  int fails  = 0;
  int acyc   = 0;
  bit cmp_on = 1'b0;
  logic [3:0] kq[$];
  logic [3:0] cur_idx;
  int exp_score = 0;
  int exp_round = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic summary_and_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  endtask

  function automatic logic [11:0] model_entry();
    logic [11:0] r;
    r = '0;
    foreach (kq[i]) r[i*4 +: 4] = kq[i];
    return r;
  endfunction

  // correct iff the typed multiset (padded with zeros to 3) equals the answer's
  function automatic bit model_judge(input logic [11:0] ans);
    int c[16];
    logic [3:0] v;
    foreach (c[i]) c[i] = 0;
    for (int i = 0; i < 3; i++) begin
      v = ans[i*4 +: 4];
      c[v]++;
      v = (i < kq.size()) ? kq[i] : 4'd0;
      c[v]--;
    end
    foreach (c[i]) if (c[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge CLK) if (cmp_on) begin
    chk("entry", 32'(ENTRY), 32'(model_entry()));
    chk("entry_cnt", 32'(ENTRY_CNT), 32'(kq.size()));
    chk("score", 32'(SCORE), 32'(exp_score));
    chk("round", 32'(ROUND), 32'(exp_round));
    chk("busy", 32'(BUSY), 32'd1);
  end

  task automatic step();
    @(posedge CLK); #1;
    acyc++;
  endtask

  task automatic start();
    START = 1'b1; step(); START = 1'b0;
  endtask

  task automatic start_at(input logic [3:0] tgt);
    logic [7:0] nl;
    for (int i = 0; i < 600; i++) begin
      nl = lfsr_next(lm);
      if (nl[3:0] == tgt) break;
      step();
    end
    start();
    exp_score = 0; exp_round = 1;
  endtask

  task automatic key(input logic [3:0] k);
    KEY_VALID = 1'b1; KEY_IDX = k; step(); KEY_VALID = 1'b0; KEY_IDX = 4'd0;
    if (k >= 4'd1 && k <= 4'd9 && kq.size() < 3) kq.push_back(k);
  endtask

  task automatic ent();
    while (acyc < 5) step();
    KEY_ENT = 1'b1; step(); KEY_ENT = 1'b0;
  endtask

  task automatic wait_answer();
    bit ok;
    logic [23:0] r;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (BUSY && !RESULT_VALID && TIME_LEFT == 8'(TL)) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin
      fails++; checks++;
      $display("FAIL answer_wait: no ANSWER state within 400 cycles");
      summary_and_end();
    end
    acyc = 0; kq.delete(); cmp_on = 1'b1; cur_idx = NUM_OUT;
    r = rom_f(cur_idx);
    chk("num_range", 32'(NUM_OUT >= 4'd1 && NUM_OUT <= 4'(QC)), 32'd1);
    chk("problem", 32'(PROBLEM_BCD), 32'(r[23:12]));
  endtask

  task automatic answer_correct();
    logic [23:0] r;
    logic [11:0] a;
    r = rom_f(cur_idx);
    a = r[11:0];
    if (a[7:4]  != 4'd0) key(a[7:4]);
    if (a[3:0]  != 4'd0) key(a[3:0]);
    if (a[11:8] != 4'd0) key(a[11:8]);
    ent();
  endtask

  // entered at the start of the JUDGE cycle
  task automatic finish_q(input bit timeout);
    bit exp_ok;
    logic [23:0] r;
    cmp_on = 1'b0;
    r = rom_f(cur_idx);
    exp_ok = !timeout && model_judge(r[11:0]);
    step();
    chk("result_valid", 32'(RESULT_VALID), 32'd1);
    chk("result_ok", 32'(RESULT_OK), 32'(exp_ok));
    if (exp_ok && exp_score < 15) exp_score++;
    chk("score_after_judge", 32'(SCORE), 32'(exp_score));
    repeat (TD) step();
    if (exp_round == NR) begin
      chk("game_done", 32'(GAME_DONE), 32'd1);
      chk("busy_done", 32'(BUSY), 32'd0);
      chk("round_done", 32'(ROUND), 32'(exp_round));
    end else begin
      exp_round++;
      chk("game_done_mid", 32'(GAME_DONE), 32'd0);
      chk("round_next", 32'(ROUND), 32'(exp_round));
      chk("busy_mid", 32'(BUSY), 32'd1);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_num"}, 32'(NUM_OUT), 32'd0);
    chk({nm, "_prob"}, 32'(PROBLEM_BCD), 32'd0);
    chk({nm, "_entry"}, 32'(ENTRY), 32'd0);
    chk({nm, "_cnt"}, 32'(ENTRY_CNT), 32'd0);
    chk({nm, "_time"}, 32'(TIME_LEFT), 32'd0);
    chk({nm, "_score"}, 32'(SCORE), 32'd0);
    chk({nm, "_round"}, 32'(ROUND), 32'd0);
    chk({nm, "_busy"}, 32'(BUSY), 32'd0);
    chk({nm, "_rvalid"}, 32'(RESULT_VALID), 32'd0);
    chk({nm, "_rok"}, 32'(RESULT_OK), 32'd0);
    chk({nm, "_done"}, 32'(GAME_DONE), 32'd0);
  endtask

  initial begin
    #500000;
    fails++; checks++;
    $display("FAIL watchdog: simulation time limit reached");
    summary_and_end();
  end

  initial begin
    logic [3:0] prev;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RST = 1'b0;

    // game A, round 1: index 2, keys 4,1,2 are a correct answer
    start_at(4'd2);
    wait_answer();
    chk("t1_num", 32'(NUM_OUT), 32'd2);
    chk("t1_prob", 32'(PROBLEM_BCD), 32'h042);
    chk("t1_time", 32'(TIME_LEFT), 32'd2);
    key(4'd4); key(4'd1); key(4'd2);
    ent();
    finish_q(1'b0);
    chk("t1_ok", 32'(RESULT_OK), 32'd1);
    chk("t1_score", 32'(SCORE), 32'd1);

    // game A, round 2: overflow key, clear-vs-key, ignored START, timeout
    wait_answer();
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    chk("t4_cnt", 32'(ENTRY_CNT), 32'd3);
    chk("t4_entry", 32'(ENTRY), 32'h321);
    KEY_CLR = 1'b1; KEY_VALID = 1'b1; KEY_IDX = 4'd4;
    step();
    KEY_CLR = 1'b0; KEY_VALID = 1'b0; KEY_IDX = 4'd0;
    kq.delete();
    chk("t4_clr_cnt", 32'(ENTRY_CNT), 32'd0);
    chk("t4_clr_entry", 32'(ENTRY), 32'h000);
    start();
    key(4'd12);
    chk("t3_time7", 32'(TIME_LEFT), 32'd1);
    chk("t3_not_judged", 32'(RESULT_VALID), 32'd0);
    step();
    chk("t3_judge_cycle", 32'(acyc), 32'd8);
    chk("t3_time0", 32'(TIME_LEFT), 32'd0);
    chk("t3_rvalid_judge", 32'(RESULT_VALID), 32'd0);
    finish_q(1'b1);
    chk("t3_ok", 32'(RESULT_OK), 32'd0);
    chk("t5a_score", 32'(SCORE), 32'd1);

    // game B: index 1, keys 2,2 are wrong; then a correct round
    start_at(4'd1);
    wait_answer();
    chk("t2_num", 32'(NUM_OUT), 32'd1);
    chk("t2_prob", 32'(PROBLEM_BCD), 32'h027);
    key(4'd2); key(4'd2);
    ent();
    finish_q(1'b0);
    chk("t2_ok", 32'(RESULT_OK), 32'd0);
    chk("t2_score", 32'(SCORE), 32'd0);
    wait_answer();
    answer_correct();
    finish_q(1'b0);

    // game C: both rounds correct
    start();
    exp_score = 0; exp_round = 1;
    for (int r = 0; r < NR; r++) begin
      wait_answer();
      answer_correct();
      finish_q(1'b0);
    end
    chk("t5_done", 32'(GAME_DONE), 32'd1);
    chk("t5_score", 32'(SCORE), 32'd2);
    chk("t5_round", 32'(ROUND), 32'd2);

    // reset in the middle of ANSWER
    start();
    exp_score = 0; exp_round = 1;
    wait_answer();
    key(4'd3);
    cmp_on = 1'b0;
    #1 RST = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    RST = 1'b0;
    step();
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_round", 32'(ROUND), 32'd0);

    // 100 rounds of picks; with no-repeat, round 2 never reuses round 1's index
    prev = 4'd0;
    for (int g = 0; g < 50; g++) begin
      start();
      exp_score = 0; exp_round = 1;
      for (int r = 0; r < NR; r++) begin
        wait_answer();
`ifdef QUIZ_SEQ_NO_REPEAT_EN
        if (r > 0) chk("no_repeat", 32'(NUM_OUT != prev), 32'd1);
`endif
        prev = NUM_OUT;
        answer_correct();
        finish_q(1'b0);
      end
      chk("loop_score", 32'(SCORE), 32'd2);
    end

    summary_and_end();
  end

endmodule

// File: doc/quiz_seq_ctrl.md
Name: quiz_seq_ctrl

Overview:
Game sequencer for the prime-factorization quiz. It picks a question index, drives the registered question ROM, and latches the 24-bit record. It then collects up to three prime-index key entries per question, judges them against the stored answer under a per-question time limit, and tracks round and score. It sits between the key/debounce front end, the question ROM and the display driver.

Parameters:
Q_COUNT, 8, highest valid ROM index; indices 1..Q_COUNT are used and 0 is the blank record.
NUM_ROUNDS, 5, number of questions per game (1..15).
TIME_LIMIT, 30, number of seconds allowed per question (1..255).
TICK_DIV, 50_000_000, number of CLK cycles per one-second tick.

Ports:
CLK  in  1  system clock; the only clock.
RST  in  1  reset, asynchronous, active-high.
START  in  1  one-cycle pulse that begins a game; honoured only in IDLE or DONE.
KEY_VALID  in  1  one-cycle strobe; KEY_IDX is valid while it is high.
KEY_IDX  in  4  prime index 1..9 (2,3,5,7,11,13,17,19,23); 0 and 10..15 are ignored.
KEY_CLR  in  1  one-cycle pulse that clears the current entries.
KEY_ENT  in  1  one-cycle pulse that submits the entries.
QUESTION  in  24  ROM record: [23:12] = three BCD problem digits; [11:0] = three 4-bit answer indices, zeros in the upper slots, nonzero values ascending.
NUM_OUT  out  4  ROM address.
PROBLEM_BCD  out  12  latched QUESTION[23:12].
ENTRY  out  12  player entries as typed, slot 0 in [3:0].
ENTRY_CNT  out  2  number of entries, 0..3.
TIME_LEFT  out  8  seconds remaining.
SCORE  out  4  count of correct answers.
ROUND  out  4  current question number, 1-based.
BUSY  out  1  high in every state except IDLE and DONE.
RESULT_VALID  out  1  high throughout RESULT.
RESULT_OK  out  1  verdict of the last judge; holds until the next JUDGE.
GAME_DONE  out  1  high in DONE.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0. The 8-bit LFSR seeds to 8'hA5.
- The LFSR (taps 8,6,5,4) advances every cycle regardless of state.
- IDLE/DONE on START: SCORE=0, ROUND=1, then go to PICK. A START pulse in any other state is ignored.
- PICK: candidate = LFSR[3:0]. If the candidate is in 1..Q_COUNT, NUM_OUT=candidate and go to FETCH; otherwise stay in PICK.
- FETCH (1 cycle): NUM_OUT is stable, and the ROM registers the record at the end of this cycle.
- LOAD (1 cycle): latch QUESTION into the problem/answer registers. Clear the entries, set TIME_LEFT=TIME_LIMIT, clear the prescaler, then go to ANSWER. Total latency from START to ANSWER is at least 4 cycles.
- ANSWER:
  - KEY_VALID with a legal index and ENTRY_CNT<3: write the index to slot ENTRY_CNT and increment ENTRY_CNT. Keys at count 3 or with an illegal index are dropped.
  - KEY_CLR: ENTRY=0, ENTRY_CNT=0.
  - KEY_ENT: go to JUDGE.
  - Prescaler wraps at TICK_DIV-1; each wrap decrements TIME_LEFT. When TIME_LEFT reaches 0, go to JUDGE (timeout).
- Same-cycle priority in ANSWER: timeout > KEY_ENT > KEY_CLR > KEY_VALID.
- JUDGE (1 cycle):
  - Sort the entries ascending with a 3-element compare/swap network, zeros to the upper slots, and compare all 12 bits with the answer.
  - RESULT_OK=1 only on an exact match with no timeout. Entering nothing matches only an all-zero answer.
  - SCORE increments on OK and saturates at 15.
- RESULT: hold for TICK_DIV cycles (1 s). Then, if ROUND==NUM_ROUNDS go to DONE; otherwise increment ROUND and go to PICK.
- DONE: GAME_DONE=1. SCORE and ROUND hold until the next START.
- RST mid-game returns to IDLE immediately. No partial state survives.

Optional Feature:
QUIZ_SEQ_NO_REPEAT_EN.
- Defined: PICK also rejects a candidate equal to the previous question index; the previous index is cleared at START.
- Undefined: any index 1..Q_COUNT is accepted, so repeats are allowed.

Decomposition:
- Package quiz_pkg holds:
  - the state enum (IDLE, PICK, FETCH, LOAD, ANSWER, JUDGE, RESULT, DONE);
  - field slice constants PROB_MSB=23, PROB_LSB=12, ANS_MSB=11;
  - width constants IDX_W=4 and REC_W=24.
- Sub-module quiz_sort3: a combinational 3-entry ascending sort with zeros high, instantiated once in JUDGE.

Test Plan:
1. Bench ROM at index 2 = 24'h042124. Keys 4,1,2 then ENT → RESULT_OK=1, SCORE=1, PROBLEM_BCD=12'h042.
2. Index 1 = 24'h027222. Keys 2,2 then ENT → RESULT_OK=0, SCORE unchanged.
3. TICK_DIV=4, TIME_LIMIT=2, no keys → JUDGE after 8 ANSWER cycles, RESULT_OK=0, TIME_LEFT=0.
4. Keys 1,2,3,5 → ENTRY_CNT=3 and ENTRY=12'h321 (4th key dropped). Then KEY_CLR and KEY_VALID=4 in the same cycle → ENTRY_CNT=0 (clear wins).
5. NUM_ROUNDS=2, both answered correctly → GAME_DONE=1, SCORE=2, ROUND=2. START during ANSWER is ignored.
6. Assert RST during ANSWER → IDLE and all outputs 0 in the same cycle. With QUIZ_SEQ_NO_REPEAT_EN, over 100 rounds no two consecutive NUM_OUT values are equal.
